stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- control FSM for a ms/s/min stopwatch counter chain.
//
// Buttons are synchronized (SYNC_STAGES flops each) and rising-edge detected
// into one-cycle events. The FSM (IDLE/RUN/PAUSE/FULL) gates the counter
// enable and issues a one-cycle clear pulse to the counter chain.
//
// Optional lap support is compiled in when the macro STOPWATCH_LAP_EN is
// defined; otherwise lap_hold is tied low and btn_lap is ignored.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   tick           in   1 kHz one-cycle pulse, synchronous to clk
//   btn_start_stop in   debounced button level, asynchronous
//   btn_clear      in   debounced button level, asynchronous
//   btn_lap        in   debounced button level, asynchronous
//   chain_carry    in   carry out of the most-significant counter
//   cnt_enable     out  count enable to the least-significant counter
//   cnt_clear      out  one-cycle clear pulse to all counters
//   lap_hold       out  display freeze request
//   state          out  FSM state (00 IDLE, 01 RUN, 10 PAUSE, 11 FULL)
module stopwatch_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic       chain_carry,
  output logic       cnt_enable,
  output logic       cnt_clear,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] clr_sync_q;
  logic                   ss_prev_q;
  logic                   clr_prev_q;
  logic                   ss_ev;
  logic                   clr_ev;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       cnt_clear_q;
  logic       cnt_clear_d;

  // Synchronizers plus the previous-value flop of each edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_sync_q  <= '0;
      clr_sync_q <= '0;
      ss_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
    end else begin
      ss_sync_q  <= {ss_sync_q[SYNC_STAGES-2:0], btn_start_stop};
      clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], btn_clear};
      ss_prev_q  <= ss_sync_q[SYNC_STAGES-1];
      clr_prev_q <= clr_sync_q[SYNC_STAGES-1];
    end
  end

  // Events are combinational off the last sync stage, so a button sampled at
  // edge 1 changes state at edge SYNC_STAGES+1.
  assign ss_ev  = ss_sync_q[SYNC_STAGES-1] & ~ss_prev_q;
  assign clr_ev = clr_sync_q[SYNC_STAGES-1] & ~clr_prev_q;

  assign cnt_enable = tick & (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    cnt_clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Clear wins over start when both arrive together.
        if (clr_ev) begin
          cnt_clear_d = 1'b1;
        end else if (ss_ev) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Overflow beats a simultaneous stop; clear is ignored while running.
        if (cnt_enable && chain_carry) begin
          state_d = FULL;
        end else if (ss_ev) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (clr_ev) begin
          state_d     = IDLE;
          cnt_clear_d = 1'b1;
        end else if (ss_ev) begin
          state_d = RUN;
        end
      end
      FULL: begin
        if (clr_ev) begin
          state_d     = IDLE;
          cnt_clear_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset never produces a clear pulse; the counters have their own reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_clear_q <= cnt_clear_d;
    end
  end

  assign state     = state_q;
  assign cnt_clear = cnt_clear_q;

`ifdef STOPWATCH_LAP_EN
  logic [SYNC_STAGES-1:0] lap_sync_q;
  logic                   lap_prev_q;
  logic                   lap_ev;
  logic                   lap_hold_q;
  logic                   lap_hold_d;

  assign lap_ev = lap_sync_q[SYNC_STAGES-1] & ~lap_prev_q;

  always_comb begin
    lap_hold_d = lap_hold_q;
    // Entering IDLE or FULL always releases the display freeze.
    if (state_d == IDLE || state_d == FULL) begin
      lap_hold_d = 1'b0;
    end else if (lap_ev && (state_q == RUN || state_q == PAUSE)) begin
      lap_hold_d = ~lap_hold_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_sync_q <= '0;
      lap_prev_q <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      lap_sync_q <= {lap_sync_q[SYNC_STAGES-2:0], btn_lap};
      lap_prev_q <= lap_sync_q[SYNC_STAGES-1];
      lap_hold_q <= lap_hold_d;
    end
  end

  assign lap_hold = lap_hold_q;
`else
  // Lap disabled: the port stays for pin compatibility but drives nothing.
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;
  assign lap_hold       = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with SYNC_STAGES=2.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_stopwatch_ctrl;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic       chain_carry = 1'b0;
  logic       cnt_enable;
  logic       cnt_clear;
  logic       lap_hold;
  logic [1:0] state;

  int vec_count = 0;
  int err_count = 0;
  logic [1:0] cur_s = IDLE;

  stopwatch_ctrl #(.SYNC_STAGES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .chain_carry    (chain_carry),
    .cnt_enable     (cnt_enable),
    .cnt_clear      (cnt_clear),
    .lap_hold       (lap_hold),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0b", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic lap_exp(input logic v);
    return LAP_EN ? v : 1'b0;
  endfunction

  // Press a button combination, check timing of the resulting transition,
  // hold it, release it and let the synchronizers settle.
  task automatic press(input logic ss, input logic clr, input logic lap, input logic ovf,
                       input logic [1:0] exp_s, input logic exp_c, input logic exp_l,
                       input int hold);
    btn_start_stop = ss;
    btn_clear      = clr;
    btn_lap        = lap;
    step();
    check("edge1_state", state, cur_s);
    step();
    check("edge2_state", state, cur_s);
    if (ovf) begin
      tick = 1'b1;
      chain_carry = 1'b1;
      #1;
      check("ovf_enable", {1'b0, cnt_enable}, 2'b01);
    end
    step();
    tick = 1'b0;
    chain_carry = 1'b0;
    check("edge3_state", state, exp_s);
    check("edge3_clear", {1'b0, cnt_clear}, {1'b0, exp_c});
    check("edge3_lap", {1'b0, lap_hold}, {1'b0, exp_l});
    step();
    check("edge4_clear", {1'b0, cnt_clear}, 2'b00);
    for (int i = 0; i < hold; i++) begin
      step();
      tick = 1'b0;
      if (i % 5 == 2) begin
        tick = 1'b1;
        #1;
        check("hold_enable", {1'b0, cnt_enable}, {1'b0, exp_s == RUN});
      end
      check("hold_state", state, exp_s);
      check("hold_lap", {1'b0, lap_hold}, {1'b0, exp_l});
    end
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    btn_lap        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tick = 1'b0;
    end
    check("settle_state", state, exp_s);
    check("settle_clear", {1'b0, cnt_clear}, 2'b00);
    cur_s = exp_s;
  endtask

  initial begin
    // Reset state, including tick high while held in reset.
    #3;
    tick = 1'b1;
    #1;
    check("rst_state", state, IDLE);
    check("rst_enable", {1'b0, cnt_enable}, 2'b00);
    check("rst_clear", {1'b0, cnt_clear}, 2'b00);
    check("rst_lap", {1'b0, lap_hold}, 2'b00);
    tick = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Idle with tick every 10 clocks: nothing moves.
    for (int i = 0; i < 20; i++) begin
      step();
      tick = (i % 10 == 0);
      #1;
      check("idle_state", state, IDLE);
      check("idle_enable", {1'b0, cnt_enable}, 2'b00);
      check("idle_clear", {1'b0, cnt_clear}, 2'b00);
    end
    tick = 1'b0;

    press(0, 1, 0, 0, IDLE,  1, 0, 0);             // clear in IDLE pulses
    press(0, 0, 1, 0, IDLE,  0, 0, 0);             // lap in IDLE ignored
    press(1, 0, 0, 0, RUN,   0, 0, 16);            // start, held long
    press(0, 1, 0, 0, RUN,   0, 0, 2);             // clear ignored in RUN
    press(0, 0, 1, 0, RUN,   0, lap_exp(1), 6);    // lap on, counting goes on
    press(0, 0, 1, 0, RUN,   0, 0, 2);             // lap off
    press(1, 0, 0, 0, PAUSE, 0, 0, 3);             // stop
    press(0, 1, 0, 0, IDLE,  1, 0, 2);             // clear from PAUSE

    press(1, 0, 0, 0, RUN,   0, 0, 2);
    press(0, 0, 1, 0, RUN,   0, lap_exp(1), 2);
    // Overflow while lap is held.
    tick = 1'b1;
    chain_carry = 1'b1;
    #1;
    check("ovf_enable", {1'b0, cnt_enable}, 2'b01);
    step();
    tick = 1'b0;
    chain_carry = 1'b0;
    check("ovf_state", state, FULL);
    check("ovf_lap", {1'b0, lap_hold}, 2'b00);
    cur_s = FULL;
    for (int i = 0; i < 3; i++) begin
      step();
      tick = 1'b1;
      #1;
      check("full_enable", {1'b0, cnt_enable}, 2'b00);
      tick = 1'b0;
    end
    press(1, 0, 0, 0, FULL,  0, 0, 3);             // start ignored in FULL
    press(0, 0, 1, 0, FULL,  0, 0, 1);             // lap ignored in FULL
    press(0, 1, 0, 0, IDLE,  1, 0, 1);             // clear from FULL

    press(1, 0, 0, 0, RUN,   0, 0, 1);
    press(1, 0, 0, 0, PAUSE, 0, 0, 1);
    press(0, 0, 1, 0, PAUSE, 0, lap_exp(1), 1);    // lap toggles in PAUSE
    press(1, 1, 0, 0, IDLE,  1, 0, 1);             // both in PAUSE: clear wins
    press(1, 0, 0, 0, RUN,   0, 0, 1);
    press(1, 1, 0, 0, PAUSE, 0, 0, 1);             // both in RUN: stop wins
    press(1, 0, 0, 0, RUN,   0, 0, 1);
    press(1, 0, 0, 1, FULL,  0, 0, 1);             // stop + overflow -> FULL
    press(0, 1, 0, 0, IDLE,  1, 0, 1);

    // Reset asserted mid-RUN forces IDLE at once and pulses no clear.
    press(1, 0, 0, 0, RUN,   0, 0, 1);
    step();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_state", state, IDLE);
    tick = 1'b1;
    #1;
    check("midrst_enable", {1'b0, cnt_enable}, 2'b00);
    tick = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("postrst_clear", {1'b0, cnt_clear}, 2'b00);
    step();
    check("postrst_state", state, IDLE);
    check("postrst_clear2", {1'b0, cnt_clear}, 2'b00);

    // Start held through reset release: one event, 3 edges later.
    reset = 1'b1;
    btn_start_stop = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check("hrst_edge1", state, IDLE);
    step();
    check("hrst_edge2", state, IDLE);
    step();
    check("hrst_edge3", state, RUN);
    for (int i = 0; i < 4; i++) begin
      step();
    end
    check("hrst_hold", state, RUN);
    btn_start_stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
    end
    cur_s = RUN;
    press(0, 1, 0, 0, RUN,   0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
